div_mul_stage: RTL

- Third stage of the divide path in the root calculator.
- Consumes the float32 reciprocal produced by recip_second_stage and multiplies it by the dividend, giving quotient = dividend × (1/divisor).
- Contains an internal delay line that aligns the dividend with the reciprocal pipeline, followed by a 2-stage pipelined IEEE-754 single-precision multiplier with valid tracking.

---
 rtl/div_mul_stage.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/div_mul_stage.sv
// Divide-path stage 3: quotient = dividend * reciprocal, float32.
// A dividend delay line aligns with the reciprocal, then a 2-stage multiplier.
module div_mul_stage #(
    parameter int unsigned RECIP_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_dividend,
    input  logic [31:0] recip,
    output logic        out_valid,
    output logic [31:0] quotient,
    output logic        busy
);

    localparam int unsigned FW = 32;
    localparam int unsigned EW = 8;
    localparam int unsigned MW = 23;
    localparam int unsigned SW = MW + 1;
    localparam int unsigned PW = 2 * SW;
    localparam int unsigned XW = 10;
    localparam int unsigned DL = (RECIP_LATENCY < 1) ? 1 : RECIP_LATENCY;

    localparam logic [FW-1:0] QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic              sign;
        logic              nan;
        logic              inf;
        logic              zero;
        logic [XW-1:0]     exp_sum;
        logic [PW-1:0]     prod;
    } stage_a_t;

    // Dividend/valid delay line
    logic [DL-1:0]  dl_valid;
    logic [FW-1:0]  dl_data [DL];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_valid <= '0;
            for (int i = 0; i < int'(DL); i++) begin
                dl_data[i] <= '0;
            end
        end else begin
            dl_valid[0] <= in_valid;
            dl_data[0]  <= in_dividend;
            for (int i = 1; i < int'(DL); i++) begin
                dl_valid[i] <= dl_valid[i-1];
                dl_data[i]  <= dl_data[i-1];
            end
        end
    end

    logic          tap_valid_c;
    logic [FW-1:0] tap_data_c;

    assign tap_valid_c = dl_valid[DL-1];
    assign tap_data_c  = dl_data[DL-1];

    // Stage A: unpack, classify, exponent sum and full significand product
    stage_a_t      stage_a_c;
    logic [EW-1:0] ea_c;
    logic [EW-1:0] eb_c;
    logic [MW-1:0] ma_c;
    logic [MW-1:0] mb_c;
    logic          a_nan_c;
    logic          b_nan_c;
    logic          a_inf_c;
    logic          b_inf_c;
    logic          a_zero_c;
    logic          b_zero_c;

    always_comb begin
        stage_a_c = '0;
        ea_c      = tap_data_c[30:23];
        eb_c      = recip[30:23];
        ma_c      = tap_data_c[22:0];
        mb_c      = recip[22:0];
        a_nan_c   = (ea_c == 8'hFF) && (ma_c != '0);
        b_nan_c   = (eb_c == 8'hFF) && (mb_c != '0);
        a_inf_c   = (ea_c == 8'hFF) && (ma_c == '0);
        b_inf_c   = (eb_c == 8'hFF) && (mb_c == '0);
        // exp=0 covers both zero and denormal: denormals are flushed
        a_zero_c  = (ea_c == '0);
        b_zero_c  = (eb_c == '0);

        stage_a_c.sign    = tap_data_c[31] ^ recip[31];
        stage_a_c.nan     = a_nan_c | b_nan_c | (a_inf_c & b_zero_c) | (b_inf_c & a_zero_c);
        stage_a_c.inf     = a_inf_c | b_inf_c;
        stage_a_c.zero    = a_zero_c | b_zero_c;
        stage_a_c.exp_sum = XW'(ea_c) + XW'(eb_c) - XW'(127);
        stage_a_c.prod    = PW'({1'b1, ma_c}) * PW'({1'b1, mb_c});
    end

    stage_a_t sa;
    logic     sa_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa_valid <= 1'b0;
            sa       <= '0;
        end else begin
            sa_valid <= tap_valid_c;
            if (tap_valid_c) begin
                sa <= stage_a_c;
            end
        end
    end

    // Stage B: normalize, round to nearest even, range-check, pack
    logic [SW-1:0]        mant_c;
    logic                 guard_c;
    logic                 sticky_c;
    logic                 round_up_c;
    logic [SW:0]          mant_r_c;
    logic [MW-1:0]        frac_c;
    logic signed [XW:0]   exp_n_c;
    logic signed [XW:0]   exp_f_c;
    logic [FW-1:0]        result_c;

    always_comb begin
        mant_c     = '0;
        guard_c    = 1'b0;
        sticky_c   = 1'b0;
        round_up_c = 1'b0;
        mant_r_c   = '0;
        frac_c     = '0;
        exp_n_c    = '0;
        exp_f_c    = '0;
        result_c   = '0;

        if (sa.prod[PW-1]) begin
            mant_c   = sa.prod[PW-1:PW-SW];
            guard_c  = sa.prod[PW-SW-1];
            sticky_c = |sa.prod[PW-SW-2:0];
        end else begin
            mant_c   = sa.prod[PW-2:PW-SW-1];
            guard_c  = sa.prod[PW-SW-2];
            sticky_c = |sa.prod[PW-SW-3:0];
        end
        exp_n_c = (XW+1)'(signed'(sa.exp_sum)) + (XW+1)'(sa.prod[PW-1]);

        round_up_c = guard_c & (sticky_c | mant_c[0]);
        mant_r_c   = {1'b0, mant_c} + (SW+1)'(round_up_c);
        // Carry out of rounding leaves 1.000..0, so only the exponent moves
        frac_c     = mant_r_c[SW] ? mant_r_c[MW:1] : mant_r_c[MW-1:0];
        exp_f_c    = exp_n_c + (XW+1)'(mant_r_c[SW]);

        if (sa.nan) begin
            result_c = QNAN;
        end else if (sa.inf) begin
            result_c = {sa.sign, 8'hFF, 23'h0};
        end else if (sa.zero) begin
            result_c = {sa.sign, 31'h0};
        end else if (exp_f_c >= 11'sd255) begin
            result_c = {sa.sign, 8'hFF, 23'h0};
        end else if (exp_f_c <= 11'sd0) begin
            result_c = {sa.sign, 31'h0};
        end else begin
            result_c = {sa.sign, exp_f_c[EW-1:0], frac_c};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            quotient  <= '0;
        end else begin
            out_valid <= sa_valid;
            if (sa_valid) begin
                quotient <= result_c;
            end
        end
    end

    assign busy = (|dl_valid) | sa_valid | out_valid;

endmodule
